uart_param_fifo: RTL and testbench



---
 rtl/uart_param_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_param_fifo.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param_fifo.sv
// uart_param_fifo: parametrised synchronous FIFO for the UART TX/RX paths.
// Arbitrary depth (no power-of-two assumption), live almost-empty/almost-full
// thresholds, pass-through write when full, sticky overrun/underrun flags,
// single-cycle flush and first-word fall-through read data.
// Optional feature macro: UART_FIFO_TIMEOUT_EN builds the idle-timeout
// detector; without it timeout_o is tied low.
module uart_param_fifo #(
  parameter  int WIDTH       = 8,
  parameter  int DEPTH       = 16,
  parameter  int TIMEOUT_CYC = 64,
  localparam int LVL_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             wen_i,
  input  logic             ren_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic             flush_i,
  input  logic [LVL_W-1:0] ae_thr_i,
  input  logic [LVL_W-1:0] af_thr_i,
  input  logic             clr_ovrn_i,
  input  logic             clr_udrn_i,
  output logic             ovrn_o,
  output logic             udrn_o,
  output logic [LVL_W-1:0] lvl_o,
  output logic             valid_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             almost_empty_o,
  output logic             almost_full_o,
  output logic             timeout_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_lvl;
  logic             r_ovrn;
  logic             r_udrn;

  logic w_empty;
  logic w_full;
  logic w_ra;
  logic w_wa;
  logic w_ovrn_set;
  logic w_udrn_set;

  // Pointer advance with explicit wrap so any DEPTH works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Accept decode: flush overrides both requests; a read frees the slot for a write to a full FIFO.
  always_comb begin
    w_empty    = (r_lvl == {LVL_W{1'b0}});
    w_full     = (r_lvl == LVL_W'(DEPTH));
    w_ra       = ren_i & ~w_empty & ~flush_i;
    w_wa       = wen_i & (~w_full | (ren_i & ~w_empty)) & ~flush_i;
    w_ovrn_set = wen_i & ~w_wa & ~flush_i;
    w_udrn_set = ren_i & w_empty & ~flush_i;
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (w_wa) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  // Pointers and occupancy; flush returns to the empty state in one cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_lvl    <= {LVL_W{1'b0}};
    end else if (flush_i) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_lvl    <= {LVL_W{1'b0}};
    end else begin
      if (w_wa) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_ra) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_wa && !w_ra) begin
        r_lvl <= r_lvl + LVL_W'(1);
      end else if (w_ra && !w_wa) begin
        r_lvl <= r_lvl - LVL_W'(1);
      end
    end
  end

  // Sticky error flags: a new event wins over a same-cycle clear; flush leaves them alone.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ovrn <= 1'b0;
      r_udrn <= 1'b0;
    end else begin
      if (w_ovrn_set) begin
        r_ovrn <= 1'b1;
      end else if (clr_ovrn_i) begin
        r_ovrn <= 1'b0;
      end
      if (w_udrn_set) begin
        r_udrn <= 1'b1;
      end else if (clr_udrn_i) begin
        r_udrn <= 1'b0;
      end
    end
  end

  // Status outputs; thresholds are compared live against the registered level.
  always_comb begin
    rdata_o        = r_mem[r_rd_ptr];
    lvl_o          = r_lvl;
    empty_o        = w_empty;
    full_o         = w_full;
    valid_o        = ~w_empty;
    ovrn_o         = r_ovrn;
    udrn_o         = r_udrn;
    almost_empty_o = (r_lvl <= ae_thr_i);
    almost_full_o  = (r_lvl >= af_thr_i);
  end

`ifdef UART_FIFO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] w_idle_nxt;
  logic             r_timeout;

  // Idle counter next value: any activity or an empty FIFO restarts it; it saturates at the limit.
  always_comb begin
    w_idle_nxt = r_idle_cnt;
    if (w_wa || w_ra || flush_i || w_empty) begin
      w_idle_nxt = {CNT_W{1'b0}};
    end else if (r_idle_cnt != CNT_W'(TIMEOUT_CYC)) begin
      w_idle_nxt = r_idle_cnt + CNT_W'(1);
    end else begin
      w_idle_nxt = r_idle_cnt;
    end
  end

  // Idle counter and registered timeout indication.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_idle_cnt <= {CNT_W{1'b0}};
      r_timeout  <= 1'b0;
    end else begin
      r_idle_cnt <= w_idle_nxt;
      r_timeout  <= (w_idle_nxt == CNT_W'(TIMEOUT_CYC));
    end
  end

  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_param_fifo.sv
// Bench for uart_param_fifo: a DEPTH=5 and a DEPTH=16 (TIMEOUT_CYC=8) instance
// share write/read/flush stimulus; a queue-based reference model per instance
// is compared against every output after every clock edge, on top of a
// directed vector table and hand-written corner sequences.
module tb_uart_param_fifo;

  localparam int D0 = 5;
  localparam int D1 = 16;
  localparam int T0 = 64;
  localparam int T1 = 8;
`ifdef UART_FIFO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] wdata;
  logic       wen, ren, flush, clr_o, clr_u;
  logic [2:0] ae5, af5;
  logic [4:0] ae16, af16;

  logic [7:0] rd5, rd16;
  logic [2:0] lvl5;
  logic [4:0] lvl16;
  logic ov5, ud5, vl5, em5, fu5, aem5, afu5, to5;
  logic ov16, ud16, vl16, em16, fu16, aem16, afu16, to16;

  uart_param_fifo #(.WIDTH(8), .DEPTH(D0), .TIMEOUT_CYC(T0)) u_d5 (
    .clk_i(clk), .reset_n_i(rst_n), .wdata_i(wdata), .wen_i(wen), .ren_i(ren),
    .rdata_o(rd5), .flush_i(flush), .ae_thr_i(ae5), .af_thr_i(af5),
    .clr_ovrn_i(clr_o), .clr_udrn_i(clr_u), .ovrn_o(ov5), .udrn_o(ud5),
    .lvl_o(lvl5), .valid_o(vl5), .empty_o(em5), .full_o(fu5),
    .almost_empty_o(aem5), .almost_full_o(afu5), .timeout_o(to5));

  uart_param_fifo #(.WIDTH(8), .DEPTH(D1), .TIMEOUT_CYC(T1)) u_d16 (
    .clk_i(clk), .reset_n_i(rst_n), .wdata_i(wdata), .wen_i(wen), .ren_i(ren),
    .rdata_o(rd16), .flush_i(flush), .ae_thr_i(ae16), .af_thr_i(af16),
    .clr_ovrn_i(clr_o), .clr_udrn_i(clr_u), .ovrn_o(ov16), .udrn_o(ud16),
    .lvl_o(lvl16), .valid_o(vl16), .empty_o(em16), .full_o(fu16),
    .almost_empty_o(aem16), .almost_full_o(afu16), .timeout_o(to16));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: queue contents, sticky flags, edge index of last "not idle" condition.
  logic [7:0] mq [2][$];
  bit         m_ovrn [2];
  bit         m_udrn [2];
  int         last_evt [2];

  typedef struct {
    bit         wen;
    bit         ren;
    logic [7:0] wd;
    bit         co;
    bit         cu;
    int         lvl;
    bit         ov;
    bit         ud;
    bit         full;
    bit         chk_rd;
    int         rd;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_ovrn[i]   = 1'b0;
      m_udrn[i]   = 1'b0;
      last_evt[i] = cyc;
    end
  endtask

  // One edge of the FIFO rules applied to the queue model.
  task automatic model_step(input int id, input int depth);
    int sz;
    bit ra, wa;
    sz = mq[id].size();
    if (flush) begin
      mq[id].delete();
      last_evt[id] = cyc;
      if (clr_o) m_ovrn[id] = 1'b0;
      if (clr_u) m_udrn[id] = 1'b0;
    end else begin
      ra = ren && (sz > 0);
      wa = wen && ((sz < depth) || ra);
      if (wen && !wa) m_ovrn[id] = 1'b1;
      else if (clr_o) m_ovrn[id] = 1'b0;
      if (ren && sz == 0) m_udrn[id] = 1'b1;
      else if (clr_u) m_udrn[id] = 1'b0;
      if (ra) void'(mq[id].pop_front());
      if (wa) mq[id].push_back(wdata);
      if (ra || wa || sz == 0) last_evt[id] = cyc;
    end
  endtask

  task automatic check_dut(input int id, input int depth, input int tcyc,
                           input int lvl, input bit emp, input bit ful, input bit vld,
                           input bit ae, input bit af, input bit ov, input bit ud,
                           input bit to, input int rd, input int aet, input int aft);
    string p;
    int    sz;
    p  = $sformatf("d%0d_", depth);
    sz = mq[id].size();
    chk({p, "lvl"},   lvl, sz);
    chk({p, "empty"}, emp, int'(sz == 0));
    chk({p, "full"},  ful, int'(sz == depth));
    chk({p, "valid"}, vld, int'(sz != 0));
    chk({p, "aempty"}, ae, int'(sz <= aet));
    chk({p, "afull"},  af, int'(sz >= aft));
    chk({p, "ovrn"},  ov, int'(m_ovrn[id]));
    chk({p, "udrn"},  ud, int'(m_udrn[id]));
    chk({p, "timeout"}, to, int'(TO_EN && (cyc - last_evt[id] >= tcyc)));
    if (sz != 0) chk({p, "rdata"}, rd, int'(mq[id][0]));
  endtask

  task automatic cmp_all();
    check_dut(0, D0, T0, int'(lvl5), em5, fu5, vl5, aem5, afu5, ov5, ud5, to5,
              int'(rd5), int'(ae5), int'(af5));
    check_dut(1, D1, T1, int'(lvl16), em16, fu16, vl16, aem16, afu16, ov16, ud16, to16,
              int'(rd16), int'(ae16), int'(af16));
  endtask

  // Advance one clock edge with the currently driven inputs and check everything.
  task automatic step();
    cyc++;
    model_step(0, D0);
    model_step(1, D1);
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic idle_inputs();
    wen = 1'b0; ren = 1'b0; flush = 1'b0; clr_o = 1'b0; clr_u = 1'b0; wdata = 8'h00;
  endtask

  function automatic vec_t mk(input bit w, input bit r, input logic [7:0] d,
                              input bit co, input bit cu, input int lv, input bit ov,
                              input bit ud, input bit fl, input bit cr, input int rdv);
    vec_t v;
    v.wen = w; v.ren = r; v.wd = d; v.co = co; v.cu = cu; v.lvl = lv;
    v.ov = ov; v.ud = ud; v.full = fl; v.chk_rd = cr; v.rd = rdv;
    return v;
  endfunction

  initial begin
    //            wen  ren  data   co   cu   lvl ov   ud   full chk  rd
    tbl[0]  = mk(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    tbl[1]  = mk(1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    tbl[2]  = mk(1'b1, 1'b0, 8'h13, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    tbl[3]  = mk(1'b1, 1'b0, 8'h14, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    tbl[4]  = mk(1'b1, 1'b0, 8'h15, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
    tbl[5]  = mk(1'b1, 1'b0, 8'h16, 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11);
    tbl[6]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
    tbl[7]  = mk(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12);
    tbl[8]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b1, 8'h13);
    tbl[9]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h14);
    tbl[10] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h15);
    tbl[11] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA);
    tbl[12] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tbl[13] = mk(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
    tbl[14] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C);
    tbl[15] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Reset state
    rst_n = 1'b0;
    idle_inputs();
    ae5 = 3'd0; af5 = 3'd0; ae16 = 5'd0; af16 = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    chk("reset_afull_thr0", int'(afu5), 1);
    rst_n = 1'b1;
    ae5 = 3'd1; af5 = 3'd4;

    // Directed table on the DEPTH=5 instance: fill, overrun, pass-through, underrun
    for (int i = 0; i < 16; i++) begin
      wen = tbl[i].wen; ren = tbl[i].ren; wdata = tbl[i].wd;
      clr_o = tbl[i].co; clr_u = tbl[i].cu;
      step();
      chk($sformatf("tbl%0d_lvl", i),  int'(lvl5), tbl[i].lvl);
      chk($sformatf("tbl%0d_ovrn", i), int'(ov5),  int'(tbl[i].ov));
      chk($sformatf("tbl%0d_udrn", i), int'(ud5),  int'(tbl[i].ud));
      chk($sformatf("tbl%0d_full", i), int'(fu5),  int'(tbl[i].full));
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), int'(rd5), tbl[i].rd);
    end
    idle_inputs();

    // Thresholds on the DEPTH=16 instance
    flush = 1'b1;
    step();
    flush = 1'b0;
    ae16 = 5'd2; af16 = 5'd4;
    for (int i = 1; i <= 4; i++) begin
      wen = 1'b1; wdata = 8'(8'h40 + i);
      step();
      chk($sformatf("thr_lvl%0d_ae", i), int'(aem16), int'(i <= 2));
      chk($sformatf("thr_lvl%0d_af", i), int'(afu16), int'(i >= 4));
    end
    wen = 1'b0;
    af16 = 5'd17;
    #1;
    chk("thr_af17", int'(afu16), 0);
    ae16 = 5'd0;
    #1;
    chk("thr_ae0", int'(aem16), 0);

    // Flush with a concurrent write at level 7
    for (int i = 0; i < 3; i++) begin
      wen = 1'b1; wdata = 8'(8'h50 + i);
      step();
    end
    chk("pre_flush_lvl", int'(lvl16), 7);
    begin
      bit ov_before;
      ov_before = m_ovrn[1];
      flush = 1'b1; wen = 1'b1; wdata = 8'hEE;
      step();
      chk("flush_lvl", int'(lvl16), 0);
      chk("flush_empty", int'(em16), 1);
      chk("flush_ovrn", int'(ov16), int'(ov_before));
    end
    flush = 1'b0; wen = 1'b1; wdata = 8'h77;
    step();
    chk("post_flush_rdata", int'(rd16), 8'h77);
    chk("post_flush_lvl", int'(lvl16), 1);

    // Idle timeout: word written at the previous edge, then idle
    wen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("timeout_k%0d", k), int'(to16), int'(TO_EN && k >= T1));
    end
    ren = 1'b1;
    step();
    chk("timeout_clr_read", int'(to16), 0);
    idle_inputs();

    // Randomized traffic in phases with different write/read pressure
    for (int ph = 0; ph < 4; ph++) begin
      int pw, pr;
      case (ph)
        0: begin pw = 70; pr = 30; end
        1: begin pw = 30; pr = 70; end
        2: begin pw = 90; pr = 85; end
        default: begin pw = 8; pr = 3; end
      endcase
      for (int n = 0; n < 150; n++) begin
        wen   = ($urandom_range(0, 99) < pw);
        ren   = ($urandom_range(0, 99) < pr);
        wdata = 8'($urandom);
        flush = ($urandom_range(0, 99) < 2);
        clr_o = ($urandom_range(0, 99) < 8);
        clr_u = ($urandom_range(0, 99) < 8);
        if ($urandom_range(0, 9) == 0) begin
          ae5 = 3'($urandom); af5 = 3'($urandom);
          ae16 = 5'($urandom); af16 = 5'($urandom);
        end
        step();
      end
    end
    idle_inputs();

    // Asynchronous reset with data held: contents are discarded immediately
    wen = 1'b1; wdata = 8'h99;
    step();
    wen = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    cmp_all();
    chk("async_rst_lvl", int'(lvl16), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
